// File: rtl/common_var_delay_line_w_valid_pkg.sv
// rtl/common_var_delay_line_w_valid_pkg.sv - shared state encodings and helpers for the delay-line family
package common_var_delay_line_w_valid_pkg;

  // Line occupancy: nothing stored, partially primed, or producing output
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Ceiling log2 for sizing pointers; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/common_sdp_ram_1r1w.sv
// rtl/common_sdp_ram_1r1w.sv - simple dual-port RAM, one synchronous write, one asynchronous read
module common_sdp_ram_1r1w #(
  parameter int DEPTH   = 16,
  parameter int NB_DATA = 8,
  parameter int AW      = 4
) (
  input  logic               clock,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  logic [NB_DATA-1:0] mem [DEPTH];

  // Write port; contents are never reset, the reader masks stale entries
  always_ff @(posedge clock) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // Read returns the pre-write contents when addresses collide
  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/common_var_delay_line_w_valid.sv
// rtl/common_var_delay_line_w_valid.sv - runtime-programmable valid-gated delay line with fill tracking
module common_var_delay_line_w_valid
  import common_var_delay_line_w_valid_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int MAX_DELAY = 16,
  parameter int NB_DELAY  = 5
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_data_in,
  input  logic                i_valid,
  input  logic [NB_DELAY-1:0] i_delay,
  input  logic                i_flush,
  output logic [NB_DATA-1:0]  o_data_out,
  output logic                o_valid,
  output logic [NB_DELAY-1:0] o_fill
);

  localparam int AW = (clog2(MAX_DELAY) < 1) ? 1 : clog2(MAX_DELAY);
  localparam int CW = NB_DELAY + 1;
  localparam logic [NB_DELAY-1:0] MAX_D = NB_DELAY'(MAX_DELAY);
  localparam logic [CW-1:0]       MAX_C = CW'(MAX_DELAY);

  logic [NB_DELAY-1:0] d_req, d_act, d_eff;
  logic [NB_DELAY-1:0] fill_q, fill_eff, fill_d;
  logic [CW-1:0]       n_ext, dm1, wr_ext;
  logic [AW-1:0]       wr_ptr, rd_addr;
  logic [NB_DATA-1:0]  ram_rd_data;
  logic                clear, hit;
  state_t              state_q, state_eff, state_d;

  // Clamp the requested delay into the supported range [1, MAX_DELAY]
  always_comb begin
    d_req = i_delay;
    if (i_delay == '0) d_req = NB_DELAY'(1);
    else if (i_delay > MAX_D) d_req = MAX_D;
  end

  // A flush or a delay change discards history; this edge runs as if freshly cleared
  always_comb begin
    clear     = i_flush || (d_req != d_act);
    d_eff     = clear ? d_req : d_act;
    fill_eff  = clear ? '0 : fill_q;
    state_eff = clear ? EMPTY : state_q;
    n_ext     = {1'b0, fill_eff} + CW'(1);
  end

  // Next state, fill update and decision whether the accepted sample emits output
  always_comb begin
    state_d = state_eff;
    fill_d  = fill_eff;
    hit     = 1'b0;
    if (i_valid) begin
      if (state_eff == RUN || n_ext >= {1'b0, d_eff}) begin
        hit     = 1'b1;
        state_d = RUN;
        fill_d  = d_eff;
      end else begin
        state_d = FILL;
        fill_d  = n_ext[NB_DELAY-1:0];
      end
    end
  end

  // Read address trails the write pointer by D-1 entries, modulo the buffer depth
  always_comb begin
    wr_ext  = CW'(wr_ptr);
    dm1     = {1'b0, d_eff} - CW'(1);
    rd_addr = (wr_ext >= dm1) ? AW'(wr_ext - dm1) : AW'(wr_ext + MAX_C - dm1);
  end

  common_sdp_ram_1r1w #(
    .DEPTH   (MAX_DELAY),
    .NB_DATA (NB_DATA),
    .AW      (AW)
  ) u_ram (
    .clock     (clock),
    .i_wr_en   (i_valid && !i_reset),
    .i_wr_addr (wr_ptr),
    .i_wr_data (i_data_in),
    .i_rd_addr (rd_addr),
    .o_rd_data (ram_rd_data)
  );

  // State, pointer and registered outputs; D=1 bypasses the RAM since it reads old contents
  always_ff @(posedge clock) begin
    if (i_reset) begin
      d_act      <= d_req;
      state_q    <= EMPTY;
      fill_q     <= '0;
      wr_ptr     <= '0;
      o_data_out <= '0;
      o_valid    <= 1'b0;
    end else begin
      d_act   <= d_req;
      state_q <= state_d;
      fill_q  <= fill_d;
      o_valid <= hit;
      if (i_valid) begin
        wr_ptr <= (wr_ptr == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (hit) begin
        o_data_out <= (d_eff == NB_DELAY'(1)) ? i_data_in : ram_rd_data;
      end else if (i_valid || clear) begin
        o_data_out <= '0;
      end
    end
  end

  assign o_fill = fill_q;

endmodule
